// File: rtl/npu_axi4lite_csr_if.sv
// Bus-width package and AXI4-Lite style CSR bus (no response codes) shared by the NPU host port.
// The Slave modport is the register-file side; Master is the host/interconnect side.
package npu_pkg;
   localparam int AXI_A_W = 32;
   localparam int AXI_D_W = 32;
   localparam int AXI_S_W = AXI_D_W / 8;
endpackage

interface AXI4LITE_BUS_SV;
   import npu_pkg::*;

   logic               wa_valid;
   logic               wa_ready;
   logic [AXI_A_W-1:0] wa_addr;
   logic               wd_valid;
   logic               wd_ready;
   logic [AXI_D_W-1:0] wd_data;
   logic [AXI_S_W-1:0] wd_strb;
   logic               wr_valid;
   logic               wr_ready;
   logic               ra_valid;
   logic               ra_ready;
   logic [AXI_A_W-1:0] ra_addr;
   logic               rd_valid;
   logic               rd_ready;
   logic [AXI_D_W-1:0] rd_data;

   modport Master (
      output wa_valid, wa_addr, input wa_ready,
      output wd_valid, wd_data, wd_strb, input wd_ready,
      input wr_valid, output wr_ready,
      output ra_valid, ra_addr, input ra_ready,
      input rd_valid, rd_data, output rd_ready
   );

   modport Slave (
      input wa_valid, wa_addr, output wa_ready,
      input wd_valid, wd_data, wd_strb, output wd_ready,
      output wr_valid, input wr_ready,
      input ra_valid, ra_addr, output ra_ready,
      output rd_valid, rd_data, input rd_ready
   );
endinterface

// File: rtl/npu_axi4lite_csr.sv
// NPU control/status register file behind an AXI4-Lite slave port: job registers, start pulse, DONE/ERR status.
// Optional interrupt output and CTRL.IRQ_EN bit are built only when NPU_CSR_IRQ_EN is defined.
module npu_axi4lite_csr
   import npu_pkg::*;
#(
   parameter logic [31:0] ID_VALUE = 32'h4E50_5501,
   parameter int          LEN_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   AXI4LITE_BUS_SV.Slave    s_axi,
   input  logic             busy_i,
   input  logic             done_i,
   output logic             start_o,
   output logic [31:0]      src_addr_o,
   output logic [31:0]      dst_addr_o,
   output logic [LEN_W-1:0] len_o
`ifdef NPU_CSR_IRQ_EN
   ,
   output logic             irq_o
`endif
);

   typedef enum logic {W_IDLE, W_RESP} wstate_t;
   typedef enum logic {R_IDLE, R_DATA} rstate_t;

   localparam logic [2:0] A_CTRL = 3'd0, A_STAT = 3'd1, A_SRC = 3'd2,
                          A_DST  = 3'd3, A_LEN  = 3'd4, A_ID   = 3'd5;

   wstate_t              r_wstate, w_wstate_nxt;
   rstate_t              r_rstate, w_rstate_nxt;
   logic                 r_wa_held, r_wd_held;
   logic [2:0]           r_wword;
   logic [AXI_D_W-1:0]   r_wdata;
   logic [AXI_S_W-1:0]   r_wstrb;
   logic [AXI_D_W-1:0]   r_rdata;
   logic [31:0]          r_src, r_dst;
   logic [LEN_W-1:0]     r_len;
   logic                 r_done, r_err, r_start;
   logic                 w_wa_hs, w_wd_hs, w_ra_hs, w_wr_upd;
   logic                 w_sel_ctrl, w_sel_stat;
   logic                 w_start_req, w_start_ok, w_start_err, w_clr_done, w_clr_err;
   logic                 w_irq_en;
   logic [31:0]          w_len_ext, w_len_new, w_wmerge, w_rmux;

   // Byte-lane merge of the held write beat over a register's current value
   function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [31:0] dat,
                                           input logic [3:0] strb);
      for (int b = 0; b < 4; b++)
         f_merge[8*b +: 8] = strb[b] ? dat[8*b +: 8] : old[8*b +: 8];
   endfunction

   assign w_wa_hs = s_axi.wa_valid & s_axi.wa_ready;
   assign w_wd_hs = s_axi.wd_valid & s_axi.wd_ready;
   assign w_ra_hs = s_axi.ra_valid & s_axi.ra_ready;

   // Write channel FSM: W_IDLE collects both beats, the update happens the cycle after both are held
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_wstate <= W_IDLE;
      else     r_wstate <= w_wstate_nxt;
   end

   always_comb begin
      w_wstate_nxt   = r_wstate;
      s_axi.wa_ready = 1'b0;
      s_axi.wd_ready = 1'b0;
      s_axi.wr_valid = 1'b0;
      w_wr_upd       = 1'b0;
      case (r_wstate)
         W_IDLE: begin
            s_axi.wa_ready = ~r_wa_held;
            s_axi.wd_ready = ~r_wd_held;
            if (r_wa_held && r_wd_held) begin
               w_wr_upd     = 1'b1;
               w_wstate_nxt = W_RESP;
            end
         end
         W_RESP: begin
            s_axi.wr_valid = 1'b1;
            if (s_axi.wr_ready) w_wstate_nxt = W_IDLE;
         end
         default: w_wstate_nxt = W_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wa_held <= 1'b0;
         r_wd_held <= 1'b0;
         r_wword   <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
      end else if (w_wr_upd) begin
         r_wa_held <= 1'b0;
         r_wd_held <= 1'b0;
      end else begin
         if (w_wa_hs) begin
            r_wa_held <= 1'b1;
            r_wword   <= s_axi.wa_addr[4:2];
         end
         if (w_wd_hs) begin
            r_wd_held <= 1'b1;
            r_wdata   <= s_axi.wd_data;
            r_wstrb   <= s_axi.wd_strb;
         end
      end
   end

   assign w_sel_ctrl  = w_wr_upd && (r_wword == A_CTRL);
   assign w_sel_stat  = w_wr_upd && (r_wword == A_STAT);
   assign w_start_req = w_sel_ctrl & r_wstrb[0] & r_wdata[0];
   assign w_start_ok  = w_start_req & ~busy_i;
   assign w_start_err = w_start_req & busy_i;
   assign w_clr_done  = w_sel_stat & r_wstrb[0] & r_wdata[1];
   assign w_clr_err   = w_sel_stat & r_wstrb[0] & r_wdata[2];

   always_comb begin
      w_len_ext            = '0;
      w_len_ext[LEN_W-1:0] = r_len;
   end

   assign w_wmerge  = f_merge(r_wword == A_SRC ? r_src : r_dst, r_wdata, r_wstrb);
   assign w_len_new = f_merge(w_len_ext, r_wdata, r_wstrb);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_src   <= '0;
         r_dst   <= '0;
         r_len   <= '0;
         r_start <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_start <= w_start_ok;
         // A set event in the same cycle as a W1C always wins
         r_done  <= done_i | (r_done & ~w_clr_done);
         r_err   <= w_start_err | (r_err & ~w_clr_err);
         if (w_wr_upd && r_wword == A_SRC) r_src <= w_wmerge;
         if (w_wr_upd && r_wword == A_DST) r_dst <= w_wmerge;
         if (w_wr_upd && r_wword == A_LEN) r_len <= w_len_new[LEN_W-1:0];
      end
   end

`ifdef NPU_CSR_IRQ_EN
   logic r_irq_en, r_irq;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_irq_en <= 1'b0;
         r_irq    <= 1'b0;
      end else begin
         if (w_sel_ctrl && r_wstrb[0]) r_irq_en <= r_wdata[1];
         r_irq <= r_irq_en & r_done;
      end
   end

   assign w_irq_en = r_irq_en;
   assign irq_o    = r_irq;
`else
   assign w_irq_en = 1'b0;
`endif

   // Read channel FSM: data registered from the map on the address handshake, held until accepted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_rstate <= R_IDLE;
      else     r_rstate <= w_rstate_nxt;
   end

   always_comb begin
      w_rstate_nxt   = r_rstate;
      s_axi.ra_ready = 1'b0;
      s_axi.rd_valid = 1'b0;
      case (r_rstate)
         R_IDLE: begin
            s_axi.ra_ready = 1'b1;
            if (s_axi.ra_valid) w_rstate_nxt = R_DATA;
         end
         R_DATA: begin
            s_axi.rd_valid = 1'b1;
            if (s_axi.rd_ready) w_rstate_nxt = R_IDLE;
         end
         default: w_rstate_nxt = R_IDLE;
      endcase
   end

   always_comb begin
      w_rmux = '0;
      case (s_axi.ra_addr[4:2])
         A_CTRL:  w_rmux = {30'b0, w_irq_en, 1'b0};
         A_STAT:  w_rmux = {29'b0, r_err, r_done, busy_i};
         A_SRC:   w_rmux = r_src;
         A_DST:   w_rmux = r_dst;
         A_LEN:   w_rmux = w_len_ext;
         A_ID:    w_rmux = ID_VALUE;
         default: w_rmux = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          r_rdata <= '0;
      else if (w_ra_hs) r_rdata <= w_rmux;
   end

   assign s_axi.rd_data = r_rdata;
   assign start_o       = r_start;
   assign src_addr_o    = r_src;
   assign dst_addr_o    = r_dst;
   assign len_o         = r_len;

endmodule

// File: tb/tb_npu_axi4lite_csr.sv
// Directed bench for npu_axi4lite_csr: register map vector table plus hand sequences for
// handshake timing, START/DONE/ERR rules, back-pressure, concurrent access and async reset.
module tb_npu_axi4lite_csr;
   import npu_pkg::*;

   localparam logic [31:0] ID = 32'h4E50_5501;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        busy_i = 1'b0;
   logic        done_i = 1'b0;
   logic        start_o;
   logic [31:0] src_addr_o, dst_addr_o;
   logic [15:0] len_o;
`ifdef NPU_CSR_IRQ_EN
   logic        irq_o;
`endif

   AXI4LITE_BUS_SV bus ();

   npu_axi4lite_csr #(.ID_VALUE(ID), .LEN_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .s_axi      (bus),
      .busy_i     (busy_i),
      .done_i     (done_i),
      .start_o    (start_o),
      .src_addr_o (src_addr_o),
      .dst_addr_o (dst_addr_o),
      .len_o      (len_o)
`ifdef NPU_CSR_IRQ_EN
      ,
      .irq_o      (irq_o)
`endif
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int start_cnt = 0;

   always @(posedge clk) if (start_o === 1'b1) start_cnt++;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [18];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name, input int t);
      if (t >= 20) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: no handshake within %0d cycles", name, t);
      end
   endtask

   // Both beats presented together; optionally raises done_i during the register-update cycle
   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input bit done_upd, output logic st);
      int  t;
      bit  ahs, dhs;
      bus.wa_addr  = a;
      bus.wd_data  = d;
      bus.wd_strb  = s;
      bus.wa_valid = 1'b1;
      bus.wd_valid = 1'b1;
      bus.wr_ready = 1'b1;
      t = 0;
      while ((bus.wa_valid || bus.wd_valid) && t < 20) begin
         ahs = bus.wa_valid && bus.wa_ready;
         dhs = bus.wd_valid && bus.wd_ready;
         @(posedge clk); #1;
         if (ahs) bus.wa_valid = 1'b0;
         if (dhs) bus.wd_valid = 1'b0;
         t++;
      end
      timeout("wr_addr_data", t);
      if (done_upd) done_i = 1'b1;
      t = 0;
      while (bus.wr_valid !== 1'b1 && t < 20) begin
         @(posedge clk); #1;
         done_i = 1'b0;
         t++;
      end
      timeout("wr_resp", t);
      done_i = 1'b0;
      st = start_o;
      @(posedge clk); #1;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic v);
      int t;
      bit hs;
      bus.ra_addr  = a;
      bus.ra_valid = 1'b1;
      bus.rd_ready = 1'b1;
      t = 0;
      while (bus.ra_valid && t < 20) begin
         hs = bus.ra_ready;
         @(posedge clk); #1;
         if (hs) bus.ra_valid = 1'b0;
         t++;
      end
      timeout("rd_addr", t);
      v = bus.rd_valid;
      d = bus.rd_data;
      @(posedge clk); #1;
   endtask

   task automatic pulse_done();
      done_i = 1'b1;
      @(posedge clk); #1;
      done_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rdat;
      logic        rv, st;
      int          c0;
      bit          ok;

      tbl[0]  = '{1'b1, 32'h0C, 32'h1122_3344, 4'h5, 32'h0};
      tbl[1]  = '{1'b0, 32'h0C, 32'h0,         4'h0, 32'h0022_0044};
      tbl[2]  = '{1'b1, 32'h10, 32'hABCD_1234, 4'hF, 32'h0};
      tbl[3]  = '{1'b0, 32'h10, 32'h0,         4'h0, 32'h0000_1234};
      tbl[4]  = '{1'b1, 32'h10, 32'h0000_FF00, 4'h2, 32'h0};
      tbl[5]  = '{1'b0, 32'h10, 32'h0,         4'h0, 32'h0000_FF34};
      tbl[6]  = '{1'b1, 32'h30, 32'h0000_5555, 4'hF, 32'h0};
      tbl[7]  = '{1'b0, 32'h13, 32'h0,         4'h0, 32'h0000_5555};
      tbl[8]  = '{1'b0, 32'h14, 32'h0,         4'h0, ID};
      tbl[9]  = '{1'b1, 32'h14, 32'hFFFF_FFFF, 4'hF, 32'h0};
      tbl[10] = '{1'b0, 32'h14, 32'h0,         4'h0, ID};
      tbl[11] = '{1'b1, 32'h18, 32'hFFFF_FFFF, 4'hF, 32'h0};
      tbl[12] = '{1'b0, 32'h18, 32'h0,         4'h0, 32'h0};
      tbl[13] = '{1'b0, 32'h1C, 32'h0,         4'h0, 32'h0};
      tbl[14] = '{1'b1, 32'h08, 32'h0000_0000, 4'h0, 32'h0};
      tbl[15] = '{1'b0, 32'h08, 32'h0,         4'h0, 32'hDEAD_BEEF};
      tbl[16] = '{1'b0, 32'h00, 32'h0,         4'h0, 32'h0};
      tbl[17] = '{1'b0, 32'h0B, 32'h0,         4'h0, 32'hDEAD_BEEF};

      bus.wa_valid = 1'b0; bus.wa_addr = '0;
      bus.wd_valid = 1'b0; bus.wd_data = '0; bus.wd_strb = '0;
      bus.wr_ready = 1'b1;
      bus.ra_valid = 1'b0; bus.ra_addr = '0;
      bus.rd_ready = 1'b1;

      // Reset state
      @(posedge clk); #1;
      chk("rst_wa_ready", bus.wa_ready, 1);
      chk("rst_wd_ready", bus.wd_ready, 1);
      chk("rst_ra_ready", bus.ra_ready, 1);
      chk("rst_wr_valid", bus.wr_valid, 0);
      chk("rst_rd_valid", bus.rd_valid, 0);
      chk("rst_rd_data", bus.rd_data, 0);
      chk("rst_start", start_o, 0);
      chk("rst_src", src_addr_o, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Address beat three cycles ahead of the data beat
      bus.wa_addr = 32'h08; bus.wa_valid = 1'b1;
      @(posedge clk); #1;
      bus.wa_valid = 1'b0;
      chk("wa_ready_held", bus.wa_ready, 0);
      repeat (2) begin @(posedge clk); #1; end
      bus.wd_data = 32'hDEAD_BEEF; bus.wd_strb = 4'hF; bus.wd_valid = 1'b1;
      @(posedge clk); #1;
      bus.wd_valid = 1'b0;
      chk("wr_valid_early", bus.wr_valid, 0);
      @(posedge clk); #1;
      chk("wr_valid_lat", bus.wr_valid, 1);
      chk("src_deadbeef", src_addr_o, 32'hDEAD_BEEF);
      @(posedge clk); #1;
      chk("wr_valid_done", bus.wr_valid, 0);

      // Register map vectors
      for (int i = 0; i < 18; i++) begin
         if (tbl[i].wr) wr(tbl[i].addr, tbl[i].data, tbl[i].strb, 1'b0, st);
         else begin
            rd(tbl[i].addr, rdat, rv);
            chk($sformatf("vec%0d_rd_valid", i), rv, 1);
            chk($sformatf("vec%0d_rd_data", i), rdat, tbl[i].exp);
         end
      end
      chk("dst_out", dst_addr_o, 32'h0022_0044);
      chk("len_out", len_o, 32'h0000_5555);

      // START with and without busy
      c0 = start_cnt;
      wr(32'h00, 32'h1, 4'hF, 1'b0, st);
      chk("start_at_update", st, 1);
      chk("start_one_cycle", start_o, 0);
      chk("start_count", start_cnt - c0, 1);
      busy_i = 1'b1;
      wr(32'h00, 32'h1, 4'hF, 1'b0, st);
      chk("start_busy_nopulse", st, 0);
      rd(32'h04, rdat, rv);
      chk("status_busy_err", rdat, 32'h5);
      chk("start_count_busy", start_cnt - c0, 1);
      busy_i = 1'b0;
      rd(32'h04, rdat, rv);
      chk("status_err", rdat, 32'h4);
      wr(32'h04, 32'h4, 4'h1, 1'b0, st);
      rd(32'h04, rdat, rv);
      chk("status_err_clr", rdat, 32'h0);

      // DONE set, set-wins-over-clear, then clear
      pulse_done();
      rd(32'h04, rdat, rv);
      chk("status_done", rdat, 32'h2);
      wr(32'h04, 32'h2, 4'h1, 1'b1, st);
      rd(32'h04, rdat, rv);
      chk("done_set_wins", rdat, 32'h2);
      wr(32'h04, 32'h2, 4'h1, 1'b0, st);
      rd(32'h04, rdat, rv);
      chk("done_clr", rdat, 32'h0);

      // IRQ_EN bit
      wr(32'h00, 32'h2, 4'hF, 1'b0, st);
`ifdef NPU_CSR_IRQ_EN
      rd(32'h00, rdat, rv);
      chk("ctrl_irq_en", rdat, 32'h2);
      pulse_done();
      @(posedge clk); #1;
      chk("irq_on", irq_o, 1);
      wr(32'h04, 32'h2, 4'h1, 1'b0, st);
      @(posedge clk); #1;
      chk("irq_off", irq_o, 0);
`else
      rd(32'h00, rdat, rv);
      chk("ctrl_irq_en_absent", rdat, 32'h0);
`endif

      // rd_ready back-pressure
      bus.ra_addr = 32'h14; bus.ra_valid = 1'b1; bus.rd_ready = 1'b0;
      @(posedge clk); #1;
      bus.ra_valid = 1'b0;
      ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (bus.rd_valid !== 1'b1 || bus.rd_data !== ID || bus.ra_ready !== 1'b0) ok = 1'b0;
         @(posedge clk); #1;
      end
      chk("rd_hold_stable", ok, 1);
      bus.rd_ready = 1'b1;
      @(posedge clk); #1;
      chk("rd_hold_release", bus.rd_valid, 0);

      // wr_ready back-pressure
      bus.wr_ready = 1'b0;
      bus.wa_addr = 32'h0C; bus.wd_data = 32'hCAFE_F00D; bus.wd_strb = 4'hF;
      bus.wa_valid = 1'b1; bus.wd_valid = 1'b1;
      @(posedge clk); #1;
      bus.wa_valid = 1'b0; bus.wd_valid = 1'b0;
      @(posedge clk); #1;
      ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (bus.wr_valid !== 1'b1 || bus.wa_ready !== 1'b0 || bus.wd_ready !== 1'b0) ok = 1'b0;
         @(posedge clk); #1;
      end
      chk("wr_hold_stable", ok, 1);
      bus.wr_ready = 1'b1;
      @(posedge clk); #1;
      chk("wr_hold_release", bus.wr_valid, 0);
      chk("dst_cafef00d", dst_addr_o, 32'hCAFE_F00D);

      // Read sampled in the write-update cycle sees the old value
      bus.wa_addr = 32'h08; bus.wd_data = 32'h1234_5678; bus.wd_strb = 4'hF;
      bus.wa_valid = 1'b1; bus.wd_valid = 1'b1;
      @(posedge clk); #1;
      bus.wa_valid = 1'b0; bus.wd_valid = 1'b0;
      bus.ra_addr = 32'h08; bus.ra_valid = 1'b1; bus.rd_ready = 1'b1;
      @(posedge clk); #1;
      bus.ra_valid = 1'b0;
      chk("conc_rd_old", bus.rd_data, 32'hDEAD_BEEF);
      chk("conc_src_new", src_addr_o, 32'h1234_5678);
      @(posedge clk); #1;

      // Asynchronous reset with a write response and read data both pending
      bus.wr_ready = 1'b0; bus.rd_ready = 1'b0;
      bus.wa_addr = 32'h10; bus.wd_data = 32'h0000_00AA; bus.wd_strb = 4'hF;
      bus.wa_valid = 1'b1; bus.wd_valid = 1'b1;
      bus.ra_addr = 32'h14; bus.ra_valid = 1'b1;
      @(posedge clk); #1;
      bus.wa_valid = 1'b0; bus.wd_valid = 1'b0; bus.ra_valid = 1'b0;
      @(posedge clk); #1;
      chk("pre_rst_wr_valid", bus.wr_valid, 1);
      #2 rst = 1'b1;
      #1;
      chk("async_wr_valid", bus.wr_valid, 0);
      chk("async_rd_valid", bus.rd_valid, 0);
      chk("async_rd_data", bus.rd_data, 0);
      chk("async_src", src_addr_o, 0);
      chk("async_dst", dst_addr_o, 0);
      chk("async_len", len_o, 0);
      chk("async_wa_ready", bus.wa_ready, 1);
      @(posedge clk); #1;
      rst = 1'b0;
      bus.wr_ready = 1'b1; bus.rd_ready = 1'b1;
      @(posedge clk); #1;
      rd(32'h04, rdat, rv);
      chk("post_rst_status", rdat, 32'h0);
      wr(32'h10, 32'h0000_0077, 4'h1, 1'b0, st);
      rd(32'h10, rdat, rv);
      chk("post_rst_len", rdat, 32'h0000_0077);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
